// File: rtl/clock_time_ctrl.sv
// Sequencer for the digital clock's BCD counter chain: per-counter enables, carry
// chaining, time-set mode with auto-timeout, field-blink masks and an hourly chime.
module clock_time_ctrl #(
    parameter int unsigned TIMEOUT     = 30,
    parameter int unsigned CHIME_TICKS = 3
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [3:0] sec_hi,
    input  logic [3:0] sec_lo,
    input  logic [3:0] min_hi,
    input  logic [3:0] min_lo,
    output logic       en_sec_lo,
    output logic       en_sec_hi,
    output logic       en_min_lo,
    output logic       en_min_hi,
    output logic       en_hr,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       chime
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] SET_HR  = 2'd1;
    localparam logic [1:0] SET_MIN = 2'd2;
    localparam logic [1:0] SET_SEC = 2'd3;

    localparam logic [5:0] TO_LIM  = 6'(TIMEOUT);
    localparam logic [3:0] CH_LOAD = 4'(CHIME_TICKS);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       phase;
    logic [5:0] to_cnt;
    logic [3:0] ch_cnt;

    logic       s59;
    logic       m59;
    logic       inc;
    logic       any_key;
    logic       timeout_hit;
    logic       run_hr;
    logic [5:0] en_raw;

    always_comb begin
        s59     = (sec_hi == 4'd5) && (sec_lo == 4'd9);
        m59     = (min_hi == 4'd5) && (min_lo == 4'd9);
        inc     = key_inc & ~key_mode;
        any_key = key_mode | key_inc;
        run_hr  = (state == RUN) && tick && s59 && m59;

        // The tick that would bring the count to TIMEOUT returns to RUN on that same edge.
        timeout_hit = (state != RUN) && tick && (to_cnt >= (TO_LIM - 6'd1));

        state_nx = state;
        if (key_mode) begin
            state_nx = state + 2'd1;
        end else if (timeout_hit) begin
            state_nx = RUN;
        end
    end

    // en_raw order: {en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr, clr_sec}
    always_comb begin
        en_raw = '0;
        case (state)
            RUN: begin
                en_raw[5] = tick;
                en_raw[4] = tick && (sec_lo == 4'd9);
                en_raw[3] = tick && s59;
                en_raw[2] = tick && s59 && (min_lo == 4'd9);
                en_raw[1] = run_hr;
            end
            SET_HR: begin
                en_raw[1] = inc;
            end
            SET_MIN: begin
                en_raw[3] = inc;
                en_raw[2] = inc && (min_lo == 4'd9);
            end
            default: begin
                en_raw[0] = inc;
            end
        endcase
    end

    // Enables are combinational from inputs, so they must be masked during reset.
    always_comb begin
        {en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr, clr_sec} = en_raw & {6{nCR}};
        mode      = state;
        blank_hr  = (state == SET_HR)  && phase;
        blank_min = (state == SET_MIN) && phase;
        blank_sec = (state == SET_SEC) && phase;
        chime     = (ch_cnt != 4'd0);
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state  <= RUN;
            phase  <= 1'b0;
            to_cnt <= '0;
            ch_cnt <= '0;
        end else begin
            state <= state_nx;

            if (any_key || (state_nx == RUN)) begin
                to_cnt <= '0;
            end else if (tick && (to_cnt != TO_LIM)) begin
                to_cnt <= to_cnt + 6'd1;
            end

            if (any_key) begin
                phase <= 1'b0;
            end else if (tick) begin
                phase <= ~phase;
            end

            if ((state == RUN) && (state_nx != RUN)) begin
                ch_cnt <= '0;
            end else if (run_hr) begin
                ch_cnt <= CH_LOAD;
            end else if (tick && (ch_cnt != 4'd0)) begin
                ch_cnt <= ch_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Randomized scoreboard bench for clock_time_ctrl: a driver pushes the expected
// output word each cycle, a negedge monitor pops and compares against the DUT.
module tb_clock_time_ctrl;

    localparam int TO_TICKS = 30;
    localparam int CH_TICKS = 3;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       tick = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [3:0] sec_hi = '0;
    logic [3:0] sec_lo = '0;
    logic [3:0] min_hi = '0;
    logic [3:0] min_lo = '0;
    logic       en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr, clr_sec;
    logic [1:0] mode;
    logic       blank_hr, blank_min, blank_sec, chime;

    clock_time_ctrl #(.TIMEOUT(TO_TICKS), .CHIME_TICKS(CH_TICKS)) dut (
        .CP(CP), .nCR(nCR), .tick(tick), .key_mode(key_mode), .key_inc(key_inc),
        .sec_hi(sec_hi), .sec_lo(sec_lo), .min_hi(min_hi), .min_lo(min_lo),
        .en_sec_lo(en_sec_lo), .en_sec_hi(en_sec_hi), .en_min_lo(en_min_lo),
        .en_min_hi(en_min_hi), .en_hr(en_hr), .clr_sec(clr_sec), .mode(mode),
        .blank_hr(blank_hr), .blank_min(blank_min), .blank_sec(blank_sec), .chime(chime)
    );

    always #5 CP = ~CP;

    // Reference model state: mode as 0..3, idle ticks in a SET mode, blink phase, chime ticks left.
    int m_mode  = 0;
    int m_idle  = 0;
    int m_phase = 0;
    int m_chime = 0;

    logic [11:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit driving_done = 0;

    // {en_sec_lo,en_sec_hi,en_min_lo,en_min_hi,en_hr,clr_sec,mode[1:0],blank_hr,blank_min,blank_sec,chime}
    function automatic logic [11:0] pack(bit esl, bit esh, bit eml, bit emh, bit ehr, bit clr,
                                         int md, bit bh, bit bm, bit bs, bit ch);
        logic [1:0] md2;
        md2 = 2'(md);
        return {esl, esh, eml, emh, ehr, clr, md2, bh, bm, bs, ch};
    endfunction

    function automatic logic [3:0] pick(int unsigned maxv);
        if ($urandom_range(0, 2) == 0) return 4'(maxv);
        return 4'($urandom_range(0, maxv));
    endfunction

    task automatic drive(int unsigned p_tick, int unsigned p_mode, int unsigned p_inc, bit rst_low);
        int  secs, mins, nxt_mode;
        bit  t, km, ki, inc_only, hr_roll;
        bit  esl, esh, eml, emh, ehr, clr;
        logic [11:0] exp_w;
        @(posedge CP);
        #1;
        t  = ($urandom_range(0, p_tick - 1) == 0);
        km = ($urandom_range(0, p_mode - 1) == 0);
        ki = ($urandom_range(0, p_inc - 1) == 0);
        nCR = !rst_low;
        tick = t;
        key_mode = km;
        key_inc = ki;
        sec_hi = pick(5);
        sec_lo = pick(9);
        min_hi = pick(5);
        min_lo = pick(9);
        secs = 10 * int'(sec_hi) + int'(sec_lo);
        mins = 10 * int'(min_hi) + int'(min_lo);
        if (rst_low) begin
            m_mode = 0; m_idle = 0; m_phase = 0; m_chime = 0;
            exp_w = '0;
        end else begin
            inc_only = ki && !km;
            {esl, esh, eml, emh, ehr, clr} = '0;
            hr_roll = 0;
            case (m_mode)
                0: begin
                    esl = t;
                    esh = t && (secs % 10 == 9);
                    eml = t && (secs == 59);
                    emh = t && (secs == 59) && (mins % 10 == 9);
                    ehr = t && (secs == 59) && (mins == 59);
                    hr_roll = ehr;
                end
                1: ehr = inc_only;
                2: begin
                    eml = inc_only;
                    emh = inc_only && (mins % 10 == 9);
                end
                default: clr = inc_only;
            endcase
            exp_w = pack(esl, esh, eml, emh, ehr, clr, m_mode,
                         m_mode == 1 && m_phase == 1, m_mode == 2 && m_phase == 1,
                         m_mode == 3 && m_phase == 1, m_chime > 0);
            // advance the model to the state after this edge
            if (km) nxt_mode = (m_mode + 1) % 4;
            else if (m_mode != 0 && t && m_idle + 1 >= TO_TICKS) nxt_mode = 0;
            else nxt_mode = m_mode;
            if (km || ki || nxt_mode == 0) m_idle = 0;
            else if (t && m_idle < TO_TICKS) m_idle = m_idle + 1;
            if (km || ki) m_phase = 0;
            else if (t) m_phase = 1 - m_phase;
            if (m_mode == 0 && nxt_mode != 0) m_chime = 0;
            else if (hr_roll) m_chime = CH_TICKS;
            else if (t && m_chime > 0) m_chime = m_chime - 1;
            m_mode = nxt_mode;
        end
        sb.push_back(exp_w);
    endtask

    always @(negedge CP) begin
        logic [11:0] act, exp_w;
        if (sb.size() > 0) begin
            exp_w = sb.pop_front();
            act = {en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr, clr_sec, mode,
                   blank_hr, blank_min, blank_sec, chime};
            n_cmp = n_cmp + 1;
            if (act !== exp_w) begin
                n_bad = n_bad + 1;
                $display("FAIL outputs @%0t: actual=%b required=%b (esl esh eml emh ehr clr mode bh bm bs ch)",
                         $time, act, exp_w);
            end
        end
    end

    initial begin
        // reset held with stimulus active, then quiet release
        repeat (6) drive(1, 1, 1, 1'b1);
        repeat (6) drive(1000000, 1000000, 1000000, 1'b0);
        // dense keys and collisions
        repeat (3000) drive(2, 4, 3, 1'b0);
        // moderate activity with frequent rollovers
        repeat (4000) drive(2, 30, 20, 1'b0);
        // sparse keys so SET modes can time out and chimes run out
        repeat (8000) drive(2, 250, 300, 1'b0);
        // bursts of reset in the middle of activity
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(20, 120)) drive(2, 25, 15, 1'b0);
            repeat ($urandom_range(1, 3)) drive(2, 3, 3, 1'b1);
        end
        repeat (2000) drive(2, 40, 30, 1'b0);
        driving_done = 1;
        repeat (4) @(negedge CP);
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: actual=%0d pending required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
